fft_sequencer: RTL and testbench

- Control block for the radix-2 in-place DIT FFT datapath.
- Walks all stages and butterflies of an N-point transform. For each butterfly it issues operand addresses, a twiddle index and mode flags to the external butterfly unit through a valid/ready handshake.
- Stalls between stages until every issued butterfly has written back, so stage s+1 never reads stale data.
- Sits between the top-level FFT control (start/done) and the butterfly/memory datapath built on the shared `Complex` arithmetic.

---
 rtl/complex_type_pkg.sv | 31 +++
 rtl/fft_addr_gen.sv | 30 +++
 rtl/fft_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fft_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_type_pkg.sv
// Shared types for the FFT datapath: complex sample format, the butterfly
// command word passed from fft_sequencer to the butterfly unit, and the
// sequencer FSM state encoding.
package complex_type;

    localparam int DATA_WIDTH   = 16;
    // Largest supported transform is 2**FFT_MAX_LOG2 points. Command fields
    // are sized for it, and smaller builds use the low bits.
    localparam int FFT_MAX_LOG2 = 10;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } Complex;

    typedef struct packed {
        logic [FFT_MAX_LOG2-1:0] addr_a;
        logic [FFT_MAX_LOG2-1:0] addr_b;
        logic [FFT_MAX_LOG2-2:0] tw_idx;
        logic                    conj;
        logic                    scale;
    } fft_cmd_t;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } fft_seq_state_e;

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT operand/twiddle address generator. Purely combinational:
// maps (stage, butterfly index) to the two in-place operand addresses and
// the twiddle ROM index.
module fft_addr_gen #(
    parameter  int N_LOG2 = 3,
    localparam int SW     = $clog2(N_LOG2 + 1),
    localparam int BW     = N_LOG2 - 1
) (
    input  logic [SW-1:0]     stage,
    input  logic [BW-1:0]     bf_idx,
    output logic [N_LOG2-1:0] addr_a,
    output logic [N_LOG2-1:0] addr_b,
    output logic [BW-1:0]     tw_idx
);

    logic [N_LOG2-1:0] b_ext;
    logic [N_LOG2-1:0] half;
    logic [N_LOG2-1:0] pos;

    // Split b into group and position within group; groups are 2*half wide
    always_comb begin
        b_ext  = {1'b0, bf_idx};
        half   = N_LOG2'(1) << stage;
        pos    = b_ext & (half - N_LOG2'(1));
        addr_a = ((b_ext >> stage) << (stage + SW'(1))) | pos;
        addr_b = addr_a + half;
        tw_idx = BW'(pos) << (SW'(N_LOG2 - 1) - stage);
    end

endmodule

// File: rtl/fft_sequencer.sv
// Control sequencer for the radix-2 in-place DIT FFT. Walks every stage and
// butterfly, issues commands to the butterfly unit over valid/ready, and
// holds off the next stage until all write-backs of the current one landed.
// Build option: FFT_SEQ_SCALE_EN drives bf_scale_o high on every command
// (block-floating 1/N scaling); when undefined bf_scale_o is tied low.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// SEQ_IDLE  | waiting for start_i; inverse_i latched on start
// SEQ_RUN   | bf_valid_o high, one butterfly per fire
// SEQ_DRAIN | all butterflies of the stage issued, waiting for write-backs
// SEQ_DONE  | done_o pulse, return to idle
module fft_sequencer
    import complex_type::*;
#(
    parameter  int N_LOG2 = 3,
    localparam int SW     = $clog2(N_LOG2 + 1),
    localparam int BW     = N_LOG2 - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              inverse_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              bf_valid_o,
    input  logic              bf_ready_i,
    output logic [N_LOG2-1:0] bf_addr_a_o,
    output logic [N_LOG2-1:0] bf_addr_b_o,
    output logic [BW-1:0]     bf_tw_idx_o,
    output logic              bf_conj_o,
    output logic              bf_scale_o,
    output logic [SW-1:0]     stage_o,
    input  logic              wb_valid_i
);

    localparam logic [BW-1:0] LAST_BF    = '1;
    localparam logic [SW-1:0] LAST_STAGE = SW'(N_LOG2 - 1);

    fft_seq_state_e    state;
    logic [SW-1:0]     stage;
    logic [BW-1:0]     bf_idx;
    logic [N_LOG2-1:0] outstanding;
    logic [N_LOG2-1:0] cnt_next;
    logic              fire;
    logic              wb_take;
    logic              scale_on;
    logic [SW-1:0]     gen_stage;
    logic [BW-1:0]     gen_bf;
    logic [N_LOG2-1:0] gen_a;
    logic [N_LOG2-1:0] gen_b;
    logic [BW-1:0]     gen_tw;
    fft_cmd_t          cmd_q;
    fft_cmd_t          cmd_next;

`ifdef FFT_SEQ_SCALE_EN
    assign scale_on   = 1'b1;
    assign bf_scale_o = cmd_q.scale;
`else
    assign scale_on   = 1'b0;
    assign bf_scale_o = 1'b0;
`endif

    fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
        .stage  (gen_stage),
        .bf_idx (gen_bf),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // Pick the (stage, butterfly) whose command gets loaded at the next edge
    always_comb begin
        gen_stage = '0;
        gen_bf    = '0;
        case (state)
            SEQ_RUN: begin
                gen_stage = stage;
                gen_bf    = bf_idx + BW'(1);
            end
            SEQ_DRAIN: gen_stage = stage + SW'(1);
            default: ;
        endcase
    end

    // Outstanding count lookahead (lets DRAIN exit the cycle the last wb lands)
    // and assembly of the next command word
    always_comb begin
        fire    = (state == SEQ_RUN) && bf_valid_o && bf_ready_i;
        wb_take = wb_valid_i && (outstanding != '0) &&
                  ((state == SEQ_RUN) || (state == SEQ_DRAIN));
        cnt_next = outstanding;
        if (fire && !wb_take)
            cnt_next = outstanding + N_LOG2'(1);
        else if (!fire && wb_take)
            cnt_next = outstanding - N_LOG2'(1);

        cmd_next        = '0;
        cmd_next.addr_a = FFT_MAX_LOG2'(gen_a);
        cmd_next.addr_b = FFT_MAX_LOG2'(gen_b);
        cmd_next.tw_idx = (FFT_MAX_LOG2 - 1)'(gen_tw);
        cmd_next.conj   = (state == SEQ_IDLE) ? inverse_i : cmd_q.conj;
        cmd_next.scale  = scale_on;
    end

    // Sequencer FSM, counters and registered command outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEQ_IDLE;
            stage       <= '0;
            bf_idx      <= '0;
            outstanding <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            bf_valid_o  <= 1'b0;
            cmd_q       <= '0;
        end else begin
            done_o      <= 1'b0;
            outstanding <= cnt_next;
            case (state)
                SEQ_IDLE: begin
                    if (start_i) begin
                        state       <= SEQ_RUN;
                        busy_o      <= 1'b1;
                        bf_valid_o  <= 1'b1;
                        stage       <= '0;
                        bf_idx      <= '0;
                        outstanding <= '0;
                        cmd_q       <= cmd_next;
                    end
                end
                SEQ_RUN: begin
                    if (fire) begin
                        if (bf_idx == LAST_BF) begin
                            state       <= SEQ_DRAIN;
                            bf_valid_o  <= 1'b0;
                            cmd_q.scale <= 1'b0;
                        end else begin
                            bf_idx <= bf_idx + BW'(1);
                            cmd_q  <= cmd_next;
                        end
                    end
                end
                SEQ_DRAIN: begin
                    if (cnt_next == '0) begin
                        if (stage == LAST_STAGE) begin
                            state  <= SEQ_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state      <= SEQ_RUN;
                            stage      <= stage + SW'(1);
                            bf_idx     <= '0;
                            bf_valid_o <= 1'b1;
                            cmd_q      <= cmd_next;
                        end
                    end
                end
                SEQ_DONE: begin
                    state  <= SEQ_IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

    assign bf_addr_a_o = cmd_q.addr_a[N_LOG2-1:0];
    assign bf_addr_b_o = cmd_q.addr_b[N_LOG2-1:0];
    assign bf_tw_idx_o = cmd_q.tw_idx[BW-1:0];
    assign bf_conj_o   = cmd_q.conj;
    assign stage_o     = stage;

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer (N_LOG2=3). Expected commands are
// pushed per started transform from an arithmetic reference; a monitor pops
// and compares on every fire, and a write-back model returns results.
module tb_fft_sequencer;

    localparam int L      = 3;
    localparam int N      = 1 << L;
    localparam int HALF_N = N / 2;
    localparam int SW     = $clog2(L + 1);
`ifdef FFT_SEQ_SCALE_EN
    localparam bit EXP_SCALE = 1'b1;
`else
    localparam bit EXP_SCALE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          inverse_i = 1'b0;
    logic          bf_ready_i = 1'b0;
    logic          wb_valid_i = 1'b0;
    logic          busy_o, done_o, bf_valid_o, bf_conj_o, bf_scale_o;
    logic [L-1:0]  bf_addr_a_o, bf_addr_b_o;
    logic [L-2:0]  bf_tw_idx_o;
    logic [SW-1:0] stage_o;

    fft_sequencer #(.N_LOG2(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .inverse_i   (inverse_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bf_valid_o  (bf_valid_o),
        .bf_ready_i  (bf_ready_i),
        .bf_addr_a_o (bf_addr_a_o),
        .bf_addr_b_o (bf_addr_b_o),
        .bf_tw_idx_o (bf_tw_idx_o),
        .bf_conj_o   (bf_conj_o),
        .bf_scale_o  (bf_scale_o),
        .stage_o     (stage_o),
        .wb_valid_i  (wb_valid_i)
    );

    typedef struct {
        int a;
        int b;
        int tw;
        bit conj;
        bit scale;
    } cmd_t;

    cmd_t exp_q[$];
    int   wb_due[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wb_lat = 1;
    int   ready_mode = 0;
    bit   haz_en = 0;
    bit   noise_en = 0;
    int   fire_idx = 0;
    int   hold_due = -1;
    int   hold_wb_cyc = -1;
    bit   haz_window = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;

    initial forever #5 clk = ~clk;

    function automatic void chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: DIT butterfly b of stage s pairs a and a+half inside a
    // group of width 2*half; twiddle step is N/(2*half).
    function automatic void push_expected(input bit inv);
        cmd_t c;
        int half, span;
        for (int s = 0; s < L; s++) begin
            for (int b = 0; b < HALF_N; b++) begin
                half    = 2 ** s;
                span    = 2 * half;
                c.a     = (b / half) * span + (b % half);
                c.b     = c.a + half;
                c.tw    = (b % half) * (N / span);
                c.conj  = inv;
                c.scale = EXP_SCALE;
                exp_q.push_back(c);
            end
        end
    endfunction

    // Butterfly-unit model: ready pattern and write-back returns
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       bf_ready_i = 1'b1;
            1:       bf_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: bf_ready_i = 1'($urandom_range(0, 1));
        endcase
        wb_valid_i = 1'b0;
        if (wb_due.size() > 0 && wb_due[0] <= cyc) begin
            if (wb_due[0] == hold_due) hold_wb_cyc = cyc;
            void'(wb_due.pop_front());
            wb_valid_i = 1'b1;
        end else if (noise_en) begin
            wb_valid_i = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: command scoreboard, hold, hazard and done checks
    initial begin
        cmd_t e;
        int   due;
        bit   held_ok = 0;
        bit   prev_done = 0;
        int   h_a = 0, h_b = 0, h_tw = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_ok   = 0;
                prev_done = 0;
                continue;
            end
            if (held_ok) begin
                chk(bf_valid_o, "hold_valid", int'(bf_valid_o), 1);
                chk(int'(bf_addr_a_o) == h_a && int'(bf_addr_b_o) == h_b && int'(bf_tw_idx_o) == h_tw,
                    "hold_cmd", int'(bf_addr_a_o), h_a);
            end
            held_ok = bf_valid_o && !bf_ready_i;
            h_a  = int'(bf_addr_a_o);
            h_b  = int'(bf_addr_b_o);
            h_tw = int'(bf_tw_idx_o);

            if (haz_window) begin
                if (hold_wb_cyc < 0 || cyc <= hold_wb_cyc) begin
                    chk(!bf_valid_o, "haz_valid_low", int'(bf_valid_o), 0);
                    chk(stage_o == 0, "haz_stage0", int'(stage_o), 0);
                end else if (bf_valid_o) begin
                    chk(cyc == hold_wb_cyc + 1, "haz_resume_cycle", cyc, hold_wb_cyc + 1);
                    chk(stage_o == 1, "haz_resume_stage", int'(stage_o), 1);
                    haz_window = 0;
                end
            end

            if (bf_valid_o && bf_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_cmd", int'(bf_addr_a_o), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk(int'(bf_addr_a_o) == e.a, "addr_a", int'(bf_addr_a_o), e.a);
                    chk(int'(bf_addr_b_o) == e.b, "addr_b", int'(bf_addr_b_o), e.b);
                    chk(int'(bf_tw_idx_o) == e.tw, "tw_idx", int'(bf_tw_idx_o), e.tw);
                    chk(bf_conj_o == e.conj, "conj", int'(bf_conj_o), int'(e.conj));
                    chk(bf_scale_o == e.scale, "scale", int'(bf_scale_o), int'(e.scale));
                end
                due = cyc + wb_lat;
                if (haz_en && fire_idx == HALF_N - 1) begin
                    due        = due + 10;
                    hold_due   = due;
                    haz_window = 1;
                end
                wb_due.push_back(due);
                fire_idx++;
            end

            if (prev_done) chk(!busy_o, "busy_after_done", int'(busy_o), 0);
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk(exp_q.size() == 0, "done_all_fired", exp_q.size(), 0);
                chk(busy_o, "busy_with_done", int'(busy_o), 1);
            end
            prev_done = done_o;
        end
    end

    task automatic issue_start(input bit inv, input int lat, input int rmode, input bit haz,
                               output int sc);
        wb_lat      = lat;
        ready_mode  = rmode;
        haz_en      = haz;
        fire_idx    = 0;
        hold_due    = -1;
        hold_wb_cyc = -1;
        done_cnt    = 0;
        done_cyc    = -1;
        push_expected(inv);
        @(posedge clk);
        #2;
        noise_en  = 0;
        start_i   = 1'b1;
        inverse_i = inv;
        sc        = cyc;
        @(posedge clk);
        #2;
        start_i = 1'b0;
        chk(busy_o, "busy_rise", int'(busy_o), 1);
        chk(bf_valid_o, "valid_rise", int'(bf_valid_o), 1);
    endtask

    task automatic run_fft(input bit inv, input int lat, input int rmode, input bit haz,
                           input bit drop, input bit restart, input bit chk_lat);
        int sc;
        int t;
        issue_start(inv, lat, rmode, haz, sc);
        if (drop) inverse_i = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 400) begin
            @(posedge clk);
            #2;
            t++;
            start_i = restart && (t == 5);
            if (drop) inverse_i = 1'($urandom_range(0, 1));
        end
        start_i = 1'b0;
        if (done_cnt == 0) chk(1'b0, "done_timeout", t, 400);
        repeat (3) @(posedge clk);
        #2;
        chk(done_cnt == 1, "single_done", done_cnt, 1);
        chk(exp_q.size() == 0, "all_cmds_fired", exp_q.size(), 0);
        chk(!busy_o, "idle_after_run", int'(busy_o), 0);
        if (chk_lat) chk(done_cyc - sc == L * (HALF_N + 1) + 1, "min_latency", done_cyc - sc, L * (HALF_N + 1) + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(!busy_o && !done_o && !bf_valid_o, {tag, "_ctrl"},
            int'({busy_o, done_o, bf_valid_o}), 0);
        chk(bf_addr_a_o == 0 && bf_addr_b_o == 0 && bf_tw_idx_o == 0, {tag, "_addr"},
            int'({bf_addr_a_o, bf_addr_b_o, bf_tw_idx_o}), 0);
        chk(!bf_conj_o && !bf_scale_o && stage_o == 0, {tag, "_misc"},
            int'({bf_conj_o, bf_scale_o, stage_o}), 0);
    endtask

    initial begin
        int sc;
        int t;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Forward, ready=1, writeback latency 3
        run_fft(1'b0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Minimum latency with one-cycle writeback
        run_fft(1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Stage hazard: 4th stage-0 writeback withheld 10 cycles
        run_fft(1'b0, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk(hold_wb_cyc > 0 && !haz_window, "haz_observed", hold_wb_cyc, 1);
        // Backpressure pattern 1,0,0,1
        run_fft(1'b0, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Inverse latched at start, inverse_i wiggled mid-run, second start ignored
        run_fft(1'b1, 3, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset during stage 1
        issue_start(1'b0, 3, 0, 1'b0, sc);
        t = 0;
        while (stage_o != 1 && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk(stage_o == 1, "reach_stage1", int'(stage_o), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        wb_due.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk(done_cnt == 0, "no_done_on_reset", done_cnt, 0);
        run_fft(1'b0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized runs with stray writebacks while idle
        for (int r = 0; r < 6; r++) begin
            noise_en = 1;
            repeat ($urandom_range(2, 5)) @(posedge clk);
            run_fft(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), 2,
                    1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
